qbus_dma_arbiter: RTL and testbench
===================================

Name: qbus_dma_arbiter

Overview:
- Qbus DMA bus-mastership controller for the MSCP board.
- Arbitrates round-robin between NREQ on-board DMA requesters (e.g. ring/command engine, data-transfer engine).
- Runs the Qbus BDMR/BDMGI/BSACK acquisition and release protocol, and propagates the grant daisy chain (BDMGO) when the board is not requesting.
- Sits beside the slave register block. Its gnt outputs enable whichever bus-cycle engine currently owns the Qbus.

Parameters:
- NREQ, 2: number of internal requesters.
- MAX_XFERS, 4: maximum bus cycles per tenure (Qbus fairness limit).
- GRANT_TIMEOUT, 1024: clock cycles allowed in REQUEST before abandoning.
- SYNC_STAGES, 2: synchronizer depth for Qbus inputs.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  NREQ  requester wants bus; hold until gnt
- gnt  out  NREQ  one-hot ownership grant, registered
- xfer_done  in  1  pulse: owner completed one Qbus cycle (BSYNC negated)
- xfer_last  in  1  qualifies xfer_done: owner has no more cycles
- busy  out  1  state != IDLE
- timeout_err  out  1  1-cycle pulse: grant never arrived
- abort  out  1  1-cycle pulse: BINIT hit during a non-IDLE state
- BDMGIf  in  1  DMA grant in, active-low
- BSYNCf  in  1  active-low
- BRPLYf  in  1  active-low
- BINITf  in  1  active-low
- BDMRg  out  1  DMA request gate drive, active-high
- BSACKg  out  1  select-acknowledge gate drive, active-high
- BDMGOg  out  1  grant-out gate drive, active-high

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset.
- Input synchronization: all *f inputs pass through SYNC_STAGES flops and are inverted to active-high (dmgi_s, sync_s, rply_s, init_s). All FSM decisions use the synced values.
- Reset, or init_s=1: state=IDLE; all outputs 0; xfer count=0; rr pointer=0. If init_s=1 arrives in a non-IDLE state, abort pulses for 1 cycle. The board stays in IDLE while init_s=1.
- IDLE:
  - BDMGOg (registered) = dmgi_s && !(|req) && !BDMRg.
  - While BDMGOg=1, it holds until dmgi_s=0, and no BDMR is raised (no stealing a passed grant).
  - If |req and BDMGOg=0 → REQUEST.
- REQUEST:
  - BDMRg=1, BDMGOg=0, wait counter increments.
  - dmgi_s=1 → WAIT_BUS.
  - Counter reaching GRANT_TIMEOUT-1 → IDLE with BDMRg=0 and timeout_err pulse. rr pointer is unchanged.
- WAIT_BUS:
  - BSACKg=1, BDMRg=0 in the same registered update.
  - Winner is latched now: first requester with req=1 at or after the rr pointer.
  - If no req is set, → RELEASE (BSACK held 1 cycle).
  - If sync_s=0 && rply_s=0, → OWNED with gnt[winner]=1 on entry.
- OWNED:
  - BSACKg=1; xfer count increments on each xfer_done.
  - xfer_done && (xfer_last || count==MAX_XFERS-1) → RELEASE. gnt goes 0 the next cycle.
  - Requesters get no preemption otherwise.
- RELEASE:
  - gnt=0; BSACKg stays 1 until sync_s=0, then BSACKg=0 → IDLE.
  - rr pointer = winner+1 mod NREQ; count=0.
  - IDLE lasts at least 1 cycle before a new BDMR.
- Invariants:
  - gnt is one-hot or zero.
  - BDMRg and BSACKg are never both 1.
  - BDMGOg=0 whenever state != IDLE.
- Req drop: a req dropping while in OWNED does not release the bus; only xfer_done does.
- Simultaneous events: xfer_done together with init_s is treated as init. A grant arriving in the same cycle as the REQUEST timeout is honoured (→ WAIT_BUS, no timeout_err).

Decomposition:
- Shared package qbus_pkg holds:
  - state enum dma_state_t {IDLE, REQUEST, WAIT_BUS, OWNED, RELEASE};
  - the Qbus register address constants (IR/SA);
  - default MAX_XFERS.
- Sub-module qbus_sync: parameterized width/depth flop synchronizer, reused for the slave-side synchronization.
- The round-robin pick is a function in qbus_pkg.

Test Plan:
- Basic tenure: req=01, BDMGIf low 10 cycles after BDMRg, bus idle → BSACKg=1 and BDMRg=0 in the same cycle, gnt=01. 4 xfer_done pulses → release after the 4th; BSACKg=0 once BSYNCf high; busy=0.
- Fairness: req=11 held across 3 tenures, xfer_last on the 1st xfer each time → gnt sequence 01, 10, 01.
- Pass-through: req=00, BDMGIf low → BDMGOg=1 after sync latency. Raise req=01 while BDMGOg=1 → BDMRg stays 0 until BDMGIf high, then BDMRg=1.
- Bus busy: grant arrives while BSYNCf low → BSACKg=1, gnt=00 until BSYNCf and BRPLYf both high, then gnt=01.
- Timeout: GRANT_TIMEOUT=16, BDMGIf never asserted → BDMRg=1 for 16 cycles, then 0, timeout_err pulse, state IDLE.
- Init: BINITf low during OWNED → next synced cycle all outputs 0, abort pulse, gnt=00. No BDMR until BINITf high.

Source files
------------

// File: rtl/qbus_pkg.sv
// Shared Qbus DMA definitions: FSM state enum, board register addresses,
// default tenure limit and the round-robin requester pick.
package qbus_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQUEST  = 3'd1,
      WAIT_BUS = 3'd2,
      OWNED    = 3'd3,
      RELEASE  = 3'd4
   } dma_state_t;

   // MSCP board registers in the 22-bit I/O page (octal 17772150 / 17772152)
   localparam logic [21:0] QBUS_IR_ADDR = 22'h3F_F468;
   localparam logic [21:0] QBUS_SA_ADDR = 22'h3F_F46A;

   localparam int unsigned QBUS_MAX_XFERS_DEF = 4;

   // Widest requester vector rr_pick handles; callers zero-extend to this.
   localparam int unsigned QBUS_MAX_REQ = 8;

   // First set bit of req at or after ptr, wrapping modulo n (n <= QBUS_MAX_REQ).
   // Returns ptr when nothing is requesting; callers qualify with |req.
   function automatic logic [2:0] rr_pick(input logic [QBUS_MAX_REQ-1:0] req,
                                          input logic [2:0]              ptr,
                                          input int unsigned             n);
      logic [2:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < QBUS_MAX_REQ; i++) begin
         idx = (32'(ptr) + i) % n;
         if (!found && (i < n) && req[3'(idx)]) begin
            pick  = 3'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/qbus_dma_arbiter_if.sv
// Requester handshake and Qbus DMA lines of the bus-mastership controller.
//   master : the arbiter (drives gnt/status and the BDMR/BSACK/BDMGO gates)
//   slave  : requesters plus the Qbus receivers (req, xfer_*, B*f inputs)
// Qbus inputs (*f) are raw active-low receiver outputs; *g are active-high
// gate drives.
interface qbus_dma_arbiter_if #(
   parameter int unsigned NREQ = 2
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic            xfer_done;
   logic            xfer_last;
   logic            busy;
   logic            timeout_err;
   logic            abort;
   logic            BDMGIf;
   logic            BSYNCf;
   logic            BRPLYf;
   logic            BINITf;
   logic            BDMRg;
   logic            BSACKg;
   logic            BDMGOg;

   modport master (
      input  req, xfer_done, xfer_last, BDMGIf, BSYNCf, BRPLYf, BINITf,
      output gnt, busy, timeout_err, abort, BDMRg, BSACKg, BDMGOg
   );

   modport slave (
      output req, xfer_done, xfer_last, BDMGIf, BSYNCf, BRPLYf, BINITf,
      input  gnt, busy, timeout_err, abort, BDMRg, BSACKg, BDMGOg
   );
endinterface

// File: rtl/qbus_sync.sv
// Multi-flop synchronizer for asynchronous Qbus receiver outputs.
//   clk_i  : sampling clock
//   rst_i  : synchronous active-high reset, loads RESET_VAL into every stage
//   d_i    : asynchronous input vector
//   q_o    : value after DEPTH flops
module qbus_sync #(
   parameter int unsigned     WIDTH     = 1,
   parameter int unsigned     DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [DEPTH*WIDTH-1:0] chain_q;

   if (DEPTH > 1) begin : g_multi
      // Stage 0 sits in the low slice; data shifts upward each clock.
      always_ff @(posedge clk_i) begin
         if (rst_i) chain_q <= {DEPTH{RESET_VAL}};
         else       chain_q <= {chain_q[(DEPTH-1)*WIDTH-1:0], d_i};
      end
   end else begin : g_single
      always_ff @(posedge clk_i) begin
         if (rst_i) chain_q <= RESET_VAL;
         else       chain_q <= d_i;
      end
   end

   assign q_o = chain_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/qbus_dma_arbiter.sv
// Qbus DMA bus-mastership controller for the MSCP board.
// Round-robin arbitrates the on-board DMA engines, runs the BDMR/BDMGI/BSACK
// acquire/release protocol and passes the grant chain on (BDMGO) when the
// board is not requesting.
//   clock, reset : system clock, synchronous active-high reset
//   bus.req/gnt  : requester handshake; gnt is registered one-hot or zero
//   bus.xfer_*   : owner reports each completed Qbus cycle / last cycle
//   bus.busy, timeout_err, abort : status (pulses are one cycle wide)
//   bus.B*f      : active-low Qbus inputs, synchronized internally
//   bus.B*g      : active-high Qbus gate drives
module qbus_dma_arbiter
   import qbus_pkg::*;
#(
   parameter int unsigned NREQ          = 2,
   parameter int unsigned MAX_XFERS     = QBUS_MAX_XFERS_DEF,
   parameter int unsigned GRANT_TIMEOUT = 1024,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                clock,
   input  logic                reset,
   qbus_dma_arbiter_if.master  bus
);

   localparam int unsigned RR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CNT_W  = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
   localparam int unsigned XFER_W = (MAX_XFERS > 1) ? $clog2(MAX_XFERS) : 1;

   localparam logic [2:0] ST_IDLE     = IDLE;
   localparam logic [2:0] ST_REQUEST  = REQUEST;
   localparam logic [2:0] ST_WAIT_BUS = WAIT_BUS;
   localparam logic [2:0] ST_OWNED    = OWNED;
   localparam logic [2:0] ST_RELEASE  = RELEASE;

   // Synchronize the active-low Qbus inputs; reset value is "negated".
   logic [3:0] sync_f;
   logic       dmgi_s, sync_s, rply_s, init_s;

   qbus_sync #(
      .WIDTH     (4),
      .DEPTH     (SYNC_STAGES),
      .RESET_VAL (4'hF)
   ) u_sync (
      .clk_i (clock),
      .rst_i (reset),
      .d_i   ({bus.BINITf, bus.BRPLYf, bus.BSYNCf, bus.BDMGIf}),
      .q_o   (sync_f)
   );

   assign {init_s, rply_s, sync_s, dmgi_s} = ~sync_f;

   logic [2:0]        state_q,   state_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [XFER_W-1:0] xfer_q,    xfer_d;
   logic [RR_W-1:0]   rr_q,      rr_d;
   logic [RR_W-1:0]   winner_q,  winner_d;
   logic [NREQ-1:0]   gnt_q,     gnt_d;
   logic              bdmr_q,    bdmr_d;
   logic              bsack_q,   bsack_d;
   logic              bdmgo_q,   bdmgo_d;
   logic              busy_q,    busy_d;
   logic              timeout_q, timeout_d;
   logic              abort_q,   abort_d;

   logic              req_any;
   logic [RR_W-1:0]   pick;
   logic [RR_W-1:0]   next_ptr;

   assign req_any  = |bus.req;
   assign pick     = RR_W'(rr_pick(QBUS_MAX_REQ'(bus.req), 3'(rr_q), NREQ));
   assign next_ptr = (winner_q == RR_W'(NREQ - 1)) ? '0 : winner_q + RR_W'(1);

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      xfer_d    = xfer_q;
      rr_d      = rr_q;
      winner_d  = winner_q;
      gnt_d     = gnt_q;
      bdmr_d    = bdmr_q;
      bsack_d   = bsack_q;
      bdmgo_d   = 1'b0;
      timeout_d = 1'b0;
      abort_d   = 1'b0;

      if (init_s) begin
         // BINIT wins over everything, including a coincident xfer_done.
         state_d = ST_IDLE;
         cnt_d   = '0;
         xfer_d  = '0;
         rr_d    = '0;
         gnt_d   = '0;
         bdmr_d  = 1'b0;
         bsack_d = 1'b0;
         abort_d = (state_q != ST_IDLE);
      end else begin
         case (state_q)
            ST_IDLE: begin
               gnt_d   = '0;
               bdmr_d  = 1'b0;
               bsack_d = 1'b0;
               cnt_d   = '0;
               if (bdmgo_q) begin
                  // A passed grant is held until upstream removes it; never stolen.
                  bdmgo_d = dmgi_s;
               end else if (req_any) begin
                  state_d = ST_REQUEST;
                  bdmr_d  = 1'b1;
               end else begin
                  bdmgo_d = dmgi_s && !bdmr_q;
               end
            end

            ST_REQUEST: begin
               // A grant in the timeout cycle is still honoured.
               if (dmgi_s) begin
                  state_d = ST_WAIT_BUS;
                  bdmr_d  = 1'b0;
                  bsack_d = 1'b1;
               end else if (cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
                  state_d   = ST_IDLE;
                  bdmr_d    = 1'b0;
                  timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            ST_WAIT_BUS: begin
               bsack_d = 1'b1;
               bdmr_d  = 1'b0;
               if (!req_any) begin
                  state_d = ST_RELEASE;
               end else if (!sync_s && !rply_s) begin
                  state_d  = ST_OWNED;
                  winner_d = pick;
                  gnt_d    = NREQ'(1) << pick;
                  xfer_d   = '0;
               end
            end

            ST_OWNED: begin
               if (bus.xfer_done) begin
                  if (bus.xfer_last || (xfer_q == XFER_W'(MAX_XFERS - 1))) begin
                     state_d = ST_RELEASE;
                     gnt_d   = '0;
                     xfer_d  = '0;
                     // Pointer only advances after a real tenure.
                     rr_d    = next_ptr;
                  end else begin
                     xfer_d = xfer_q + XFER_W'(1);
                  end
               end
            end

            ST_RELEASE: begin
               gnt_d = '0;
               if (!sync_s) begin
                  state_d = ST_IDLE;
                  bsack_d = 1'b0;
               end
            end

            default: begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               bdmr_d  = 1'b0;
               bsack_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         xfer_q    <= '0;
         rr_q      <= '0;
         winner_q  <= '0;
         gnt_q     <= '0;
         bdmr_q    <= 1'b0;
         bsack_q   <= 1'b0;
         bdmgo_q   <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         xfer_q    <= xfer_d;
         rr_q      <= rr_d;
         winner_q  <= winner_d;
         gnt_q     <= gnt_d;
         bdmr_q    <= bdmr_d;
         bsack_q   <= bsack_d;
         bdmgo_q   <= bdmgo_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         abort_q   <= abort_d;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.BDMRg       = bdmr_q;
   assign bus.BSACKg      = bsack_q;
   assign bus.BDMGOg      = bdmgo_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = timeout_q;
   assign bus.abort       = abort_q;

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Bench for qbus_dma_arbiter: directed protocol scenarios followed by
// randomized tenures scored against a round-robin / tenure-length model.
module tb_qbus_dma_arbiter;

   localparam int unsigned NREQ          = 2;
   localparam int unsigned MAX_XFERS     = 4;
   localparam int unsigned GRANT_TIMEOUT = 16;
   localparam int unsigned SYNC_STAGES   = 2;

   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   viol  = 0;
   int   ptr   = 0;

   qbus_dma_arbiter_if #(.NREQ(NREQ)) bus ();

   qbus_dma_arbiter #(
      .NREQ          (NREQ),
      .MAX_XFERS     (MAX_XFERS),
      .GRANT_TIMEOUT (GRANT_TIMEOUT),
      .SYNC_STAGES   (SYNC_STAGES)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // Protocol invariants, checked every cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.BDMRg && bus.BSACKg) viol++;
         if (!$onehot0(bus.gnt))      viol++;
         if (bus.BDMGOg && bus.busy)  viol++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic cond(input int sel);
      case (sel)
         0:       return bus.BDMRg;
         1:       return bus.BSACKg;
         2:       return |bus.gnt;
         3:       return bus.BDMGOg;
         4:       return bus.abort;
         default: return bus.busy;
      endcase
   endfunction

   task automatic wait_until(input int sel, input logic val, input int budget, input string tag);
      int n = 0;
      while (cond(sel) !== val && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(cond(sel)), 32'(val));
   endtask

   // Reference: first requester at or after p, wrapping.
   function automatic int rr_model(input logic [NREQ-1:0] r, input int p);
      int w = -1;
      logic [NREQ-1:0] sh;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sh = r >> ((p + k) % NREQ);
         if (sh[0]) w = (p + k) % NREQ;
      end
      return w;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int w);
      return NREQ'(1) << w;
   endfunction

   task automatic do_reset();
      rst            = 1'b1;
      bus.req        = '0;
      bus.xfer_done  = 1'b0;
      bus.xfer_last  = 1'b0;
      bus.BDMGIf     = 1'b1;
      bus.BSYNCf     = 1'b1;
      bus.BRPLYf     = 1'b1;
      bus.BINITf     = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      ptr = 0;
   endtask

   task automatic acquire(input string tag, input int gap);
      wait_until(0, 1'b1, 40, {tag, "_bdmr"});
      repeat (gap) tick();
      bus.BDMGIf = 1'b0;
      wait_until(1, 1'b1, 8, {tag, "_bsack"});
      chk({tag, "_bdmr_off"}, 32'(bus.BDMRg), 32'd0);
      bus.BDMGIf = 1'b1;
      wait_until(2, 1'b1, 10, {tag, "_gnt"});
   endtask

   task automatic pulse(input logic last);
      bus.xfer_done = 1'b1;
      bus.xfer_last = last;
      tick();
      bus.xfer_done = 1'b0;
      bus.xfer_last = 1'b0;
   endtask

   initial begin
      logic [1:0]      fair_exp [3];
      logic [NREQ-1:0] r;
      int              w, last, exp_n, hi;

      fair_exp = '{2'b01, 2'b10, 2'b01};

      // Reset state
      do_reset();
      chk("rst_gnt",     32'(bus.gnt),         32'd0);
      chk("rst_bdmr",    32'(bus.BDMRg),       32'd0);
      chk("rst_bsack",   32'(bus.BSACKg),      32'd0);
      chk("rst_bdmgo",   32'(bus.BDMGOg),      32'd0);
      chk("rst_busy",    32'(bus.busy),        32'd0);
      chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
      chk("rst_abort",   32'(bus.abort),       32'd0);

      // Basic tenure: grant 10 cycles after BDMR, four cycles, release on BSYNC
      bus.req = 2'b01;
      wait_until(0, 1'b1, 10, "t1_bdmr");
      repeat (10) tick();
      chk("t1_bdmr_hold", 32'(bus.BDMRg), 32'd1);
      bus.BDMGIf = 1'b0;
      wait_until(1, 1'b1, 8, "t1_bsack");
      chk("t1_bdmr_off", 32'(bus.BDMRg), 32'd0);
      bus.BDMGIf = 1'b1;
      wait_until(2, 1'b1, 8, "t1_gnt");
      chk("t1_gnt_val", 32'(bus.gnt), 32'h1);
      bus.req    = '0;      // dropping req must not release the bus
      bus.BSYNCf = 1'b0;
      repeat (2) tick();
      for (int k = 1; k <= 4; k++) begin
         pulse(1'b0);
         if (k < 4) chk("t1_gnt_hold", 32'(bus.gnt), 32'h1);
      end
      chk("t1_gnt_rel",   32'(bus.gnt),    32'd0);
      chk("t1_bsack_rel", 32'(bus.BSACKg), 32'd1);
      repeat (3) tick();
      chk("t1_bsack_wait", 32'(bus.BSACKg), 32'd1);
      bus.BSYNCf = 1'b1;
      wait_until(1, 1'b0, 8, "t1_bsack_drop");
      chk("t1_busy", 32'(bus.busy), 32'd0);

      // Fairness: both requesting, single-cycle tenures
      do_reset();
      bus.req = 2'b11;
      for (int t = 0; t < 3; t++) begin
         acquire("t2", 2);
         chk("t2_gnt_seq", 32'(bus.gnt), 32'(fair_exp[t]));
         if (t == 2) bus.req = '0;
         pulse(1'b1);
         chk("t2_gnt_rel", 32'(bus.gnt), 32'd0);
      end
      wait_until(5, 1'b0, 10, "t2_idle");

      // Pass-through: grant passed on, then not stolen by a late request
      do_reset();
      bus.BDMGIf = 1'b0;
      wait_until(3, 1'b1, 6, "t3_bdmgo");
      bus.req = 2'b01;
      repeat (5) tick();
      chk("t3_no_steal", 32'(bus.BDMRg),  32'd0);
      chk("t3_go_hold",  32'(bus.BDMGOg), 32'd1);
      bus.BDMGIf = 1'b1;
      wait_until(0, 1'b1, 8, "t3_bdmr_late");
      chk("t3_go_off", 32'(bus.BDMGOg), 32'd0);
      acquire("t3", 0);
      chk("t3_gnt", 32'(bus.gnt), 32'h1);
      bus.req = '0;
      pulse(1'b1);
      chk("t3_gnt_rel", 32'(bus.gnt), 32'd0);

      // Bus busy: grant while another master's cycle is in progress
      do_reset();
      bus.BSYNCf = 1'b0;
      bus.req    = 2'b01;
      wait_until(0, 1'b1, 10, "t4_bdmr");
      bus.BDMGIf = 1'b0;
      wait_until(1, 1'b1, 8, "t4_bsack");
      bus.BDMGIf = 1'b1;
      repeat (5) tick();
      chk("t4_gnt_sync", 32'(bus.gnt),    32'd0);
      chk("t4_bsack",    32'(bus.BSACKg), 32'd1);
      bus.BSYNCf = 1'b1;
      bus.BRPLYf = 1'b0;
      repeat (5) tick();
      chk("t4_gnt_rply", 32'(bus.gnt), 32'd0);
      bus.BRPLYf = 1'b1;
      wait_until(2, 1'b1, 6, "t4_gnt_wait");
      chk("t4_gnt", 32'(bus.gnt), 32'h1);
      bus.req = '0;
      pulse(1'b1);
      wait_until(1, 1'b0, 6, "t4_bsack_drop");

      // Grant timeout
      do_reset();
      bus.req = 2'b01;
      wait_until(0, 1'b1, 10, "t5_bdmr");
      hi = 1;
      while (bus.BDMRg === 1'b1 && hi < 40) begin
         tick();
         if (bus.BDMRg === 1'b1) hi++;
      end
      chk("t5_bdmr_len", 32'(hi), 32'(GRANT_TIMEOUT));
      chk("t5_tmo",      32'(bus.timeout_err), 32'd1);
      chk("t5_busy",     32'(bus.busy),        32'd0);
      bus.req = '0;
      tick();
      chk("t5_tmo_pulse", 32'(bus.timeout_err), 32'd0);

      // BINIT during OWNED
      do_reset();
      bus.req = 2'b01;
      acquire("t6", 1);
      bus.BINITf = 1'b0;
      wait_until(4, 1'b1, 6, "t6_abort");
      chk("t6_gnt",   32'(bus.gnt),    32'd0);
      chk("t6_bsack", 32'(bus.BSACKg), 32'd0);
      chk("t6_bdmr",  32'(bus.BDMRg),  32'd0);
      chk("t6_busy",  32'(bus.busy),   32'd0);
      tick();
      chk("t6_abort_pulse", 32'(bus.abort), 32'd0);
      repeat (8) tick();
      chk("t6_hold_bdmr", 32'(bus.BDMRg), 32'd0);
      chk("t6_hold_busy", 32'(bus.busy),  32'd0);
      bus.BINITf = 1'b1;
      wait_until(0, 1'b1, 8, "t6_bdmr_resume");

      // Randomized tenures against the reference model
      do_reset();
      for (int t = 0; t < 30; t++) begin
         r       = NREQ'($urandom_range(1, 3));
         bus.req = r;
         w       = rr_model(r, ptr);
         acquire("rnd", int'($urandom_range(0, 8)));
         chk("rnd_gnt", 32'(bus.gnt), 32'(onehot(w)));
         ptr        = (w + 1) % NREQ;
         bus.BSYNCf = 1'b0;
         repeat (2) tick();
         last  = int'($urandom_range(1, 6));
         exp_n = (last < int'(MAX_XFERS)) ? last : int'(MAX_XFERS);
         for (int k = 1; k <= exp_n; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            pulse(k == last);
            if (k < exp_n) chk("rnd_hold", 32'(bus.gnt), 32'(onehot(w)));
         end
         chk("rnd_rel",       32'(bus.gnt),    32'd0);
         chk("rnd_bsack_rel", 32'(bus.BSACKg), 32'd1);
         repeat ($urandom_range(0, 3)) tick();
         bus.BSYNCf = 1'b1;
         wait_until(1, 1'b0, 8, "rnd_bsack_drop");
      end
      bus.req = '0;
      repeat (4) tick();

      chk("invariants", 32'(viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
